// File: rtl/prng_stream_if.sv
// Stream bundle for prng_stream: reseed/seed control in, valid/ready word stream and status out.
// The producer takes the master view and the consumer or bench takes the slave view.
interface prng_stream_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             reseed;
  logic [WIDTH-1:0] seed;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] rand_word;
  logic [CNT_W-1:0] count;
  logic             seed_err;
  logic             period_done;

  modport master (
    input  reseed, seed, out_ready,
    output out_valid, rand_word, count, seed_err, period_done
  );

  modport slave (
    output reseed, seed, out_ready,
    input  out_valid, rand_word, count, seed_err, period_done
  );
endinterface

// File: rtl/prng_stream.sv
// Fibonacci LFSR word source with a valid/ready output, configurable taps and shifts per word.
// It substitutes a fixed state for zero seeds and zero lock-up, and detects a return to the seed.
module prng_stream #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] POLY     = 8'hB8,
  parameter int               STEPS    = 1,
  parameter logic [WIDTH-1:0] ZERO_SUB = 8'h01,
  parameter int               CNT_W    = 16
) (
  input  logic          clk,
  input  logic          nRst,
  prng_stream_if.master strm
);

  localparam logic [0:0] UNSEEDED = 1'b0;
  localparam logic [0:0] RUN      = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] rand_q, rand_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             seed_err_q, seed_err_d;
  logic             period_done_q, period_done_d;
  logic [WIDTH-1:0] adv;
  logic [WIDTH-1:0] seed_sub;

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] v;
    v = s;
    for (int i = 0; i < STEPS; i++) begin
      v = {^(v & POLY), v[WIDTH-1:1]};
    end
    return v;
  endfunction

  assign adv      = advance(rand_q);
  assign seed_sub = (strm.seed == '0) ? ZERO_SUB : strm.seed;

  always_comb begin
    state_d       = state_q;
    rand_d        = rand_q;
    seed_d        = seed_q;
    count_d       = count_q;
    seed_err_d    = 1'b0;
    period_done_d = 1'b0;
    if (strm.reseed) begin
      // Reseed wins over a simultaneous accept; that word is not counted.
      state_d    = RUN;
      rand_d     = seed_sub;
      seed_d     = seed_sub;
      count_d    = '0;
      seed_err_d = (strm.seed == '0);
    end else if ((state_q == RUN) && strm.out_ready) begin
      count_d = count_q + CNT_W'(1);
      if (adv == '0) begin
        rand_d     = ZERO_SUB;
        seed_err_d = 1'b1;
      end else begin
        rand_d = adv;
      end
      // Compare the state actually loaded, so a lock-up recovery onto the seed also closes a period.
      period_done_d = (rand_d == seed_q);
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q       <= UNSEEDED;
      rand_q        <= '0;
      seed_q        <= '0;
      count_q       <= '0;
      seed_err_q    <= 1'b0;
      period_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rand_q        <= rand_d;
      seed_q        <= seed_d;
      count_q       <= count_d;
      seed_err_q    <= seed_err_d;
      period_done_q <= period_done_d;
    end
  end

  assign strm.out_valid   = (state_q == RUN);
  assign strm.rand_word   = rand_q;
  assign strm.count       = count_q;
  assign strm.seed_err    = seed_err_q;
  assign strm.period_done = period_done_q;

endmodule
